// File: rtl/th99_bus_pkg.sv
// th99_bus_pkg: shared types, widths and default timing for the TH99 bus master.
package th99_bus_pkg;

    localparam int TH99_AW = 16;
    localparam int TH99_DW = 8;

    localparam int TH99_T_ALE = 2;
    localparam int TH99_T_AH  = 1;
    localparam int TH99_T_SU  = 1;
    localparam int TH99_T_STB = 3;
    localparam int TH99_T_HLD = 1;

    typedef enum logic [2:0] {
        IDLE,
        AHI_ALE,
        AHI_HOLD,
        ALO_ALE,
        ALO_HOLD,
        SETUP,
        STROBE,
        HOLD
    } th99_state_e;

    // The phase timer reaches 0 on the last cycle of a phase, so it is loaded with length-1.
    function automatic logic [7:0] th99_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

    function automatic th99_state_e th99_next(input th99_state_e s);
        case (s)
            IDLE:     return AHI_ALE;
            AHI_ALE:  return AHI_HOLD;
            AHI_HOLD: return ALO_ALE;
            ALO_ALE:  return ALO_HOLD;
            ALO_HOLD: return SETUP;
            SETUP:    return STROBE;
            STROBE:   return HOLD;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/th99_phase_timer.sv
// th99_phase_timer: loadable 8-bit down-counter that flags the final cycle of a bus phase.
module th99_phase_timer (
    input  logic       clock,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = load_i ? load_val_i : (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = cnt_q == 8'd0;

endmodule

// File: rtl/th99_bus_master.sv
// th99_bus_master: single-beat TH99 bus initiator; two ALE address bytes, then one
// read or write strobe, completing with a one-cycle response pulse.
module th99_bus_master
    import th99_bus_pkg::*;
#(
    parameter int T_ALE = TH99_T_ALE,
    parameter int T_AH  = TH99_T_AH,
    parameter int T_SU  = TH99_T_SU,
    parameter int T_STB = TH99_T_STB,
    parameter int T_HLD = TH99_T_HLD
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [TH99_AW-1:0] req_addr,
    input  logic [TH99_DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [TH99_DW-1:0] rsp_rdata,
    output logic               cs_n,
    output logic [7:0]         abus,
    output logic               ale,
    output logic               r_n,
    output logic               w_n,
    inout  logic [TH99_DW-1:0] dbus
);

    if (T_ALE < 1 || T_ALE > 255 || T_AH < 1 || T_AH > 255 || T_SU < 1 || T_SU > 255 ||
        T_STB < 1 || T_STB > 255 || T_HLD < 1 || T_HLD > 255) begin : g_bad_param
        $fatal(1, "th99_bus_master: timing parameters must lie in 1..255");
    end

    th99_state_e        state_q;
    th99_state_e        state_d;
    logic               done;
    logic               accept;
    logic               finish;
    logic               tmr_load;
    logic [7:0]         tmr_val;
    logic               write_q;
    logic [7:0]         addr_lo_q;
    logic [TH99_DW-1:0] wdata_q;
    logic [TH99_DW-1:0] rd_q;
    logic               cs_n_q;
    logic               ale_q;
    logic               r_n_q;
    logic               w_n_q;
    logic               oe_q;
    logic               ready_q;
    logic               rsp_valid_q;
    logic [7:0]         abus_q;
    logic [TH99_DW-1:0] rsp_rdata_q;

    th99_phase_timer u_timer (
        .clock      (clock),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (done)
    );

    // Every state change reloads the timer with the length of the phase being entered.
    always_comb begin
        accept   = req_valid && ready_q;
        finish   = state_q == HOLD && done;
        state_d  = (state_q == IDLE) ? (accept ? AHI_ALE : IDLE)
                 : done ? th99_next(state_q) : state_q;
        tmr_load = state_d != state_q;
        tmr_val  = (state_d == AHI_ALE || state_d == ALO_ALE)   ? th99_load(T_ALE)
                 : (state_d == AHI_HOLD || state_d == ALO_HOLD) ? th99_load(T_AH)
                 : (state_d == SETUP)                           ? th99_load(T_SU)
                 : (state_d == STROBE)                          ? th99_load(T_STB)
                 : (state_d == HOLD)                            ? th99_load(T_HLD)
                 : 8'd0;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_lo_q   <= 8'd0;
            wdata_q     <= '0;
            rd_q        <= '0;
            cs_n_q      <= 1'b1;
            ale_q       <= 1'b0;
            r_n_q       <= 1'b1;
            w_n_q       <= 1'b1;
            oe_q        <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            abus_q      <= 8'd0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q   <= req_write;
                addr_lo_q <= req_addr[7:0];
                wdata_q   <= req_wdata;
            end
            cs_n_q      <= state_d == IDLE;
            ale_q       <= state_d == AHI_ALE || state_d == ALO_ALE;
            abus_q      <= accept ? req_addr[15:8]
                         : (state_d == ALO_ALE && state_q != ALO_ALE) ? addr_lo_q : abus_q;
            oe_q        <= write_q && (state_d == SETUP || state_d == STROBE || state_d == HOLD);
            r_n_q       <= !(state_d == STROBE && !write_q);
            w_n_q       <= !(state_d == STROBE && write_q);
            ready_q     <= state_d == IDLE;
            rsp_valid_q <= finish;
            // Read data is taken on the edge that ends the strobe, while r_n is still low.
            if (state_q == STROBE && done && !write_q) begin
                rd_q <= dbus;
            end
            if (finish) begin
                rsp_rdata_q <= write_q ? '0 : rd_q;
            end
        end
    end

    assign dbus      = oe_q ? wdata_q : {TH99_DW{1'bz}};
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cs_n      = cs_n_q;
    assign abus      = abus_q;
    assign ale       = ale_q;
    assign r_n       = r_n_q;
    assign w_n       = w_n_q;

endmodule

// File: tb/tb_th99_bus_master.sv
// tb_th99_bus_master: drives requests into a default-timing and an all-ones-timing master,
// models the peripheral side, and scores responses and bus waveforms against expectations.
module tb_th99_bus_master;

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          acc;
    } txn_t;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  pd;
        logic [7:0]  exp_rd;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic [7:0]  periph_d = 8'd0;

    logic       ready0, rspv0, cs0, ale0, rn0, wn0;
    logic       ready1, rspv1, cs1, ale1, rn1, wn1;
    logic [7:0] rd0, abus0, rd1, abus1;
    wire  [7:0] dbus0;
    wire  [7:0] dbus1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tale, tah, tsu, tstb, thld;
    txn_t sbq[$];

    assign dbus0 = !rn0 ? periph_d : 8'hzz;
    assign dbus1 = !rn1 ? periph_d : 8'hzz;

    wire       m_ready = sel ? ready1 : ready0;
    wire       m_rspv  = sel ? rspv1 : rspv0;
    wire [7:0] m_rd    = sel ? rd1 : rd0;
    wire       m_cs    = sel ? cs1 : cs0;
    wire [7:0] m_abus  = sel ? abus1 : abus0;
    wire       m_ale   = sel ? ale1 : ale0;
    wire       m_rn    = sel ? rn1 : rn0;
    wire       m_wn    = sel ? wn1 : wn0;
    wire [7:0] m_dbus  = sel ? dbus1 : dbus0;

    th99_bus_master dut0 (
        .clock(clock), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv0), .rsp_rdata(rd0), .cs_n(cs0), .abus(abus0), .ale(ale0),
        .r_n(rn0), .w_n(wn0), .dbus(dbus0)
    );

    th99_bus_master #(.T_ALE(1), .T_AH(1), .T_SU(1), .T_STB(1), .T_HLD(1)) dut1 (
        .clock(clock), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv1), .rsp_rdata(rd1), .cs_n(cs1), .abus(abus1), .ale(ale1),
        .r_n(rn1), .w_n(wn1), .dbus(dbus1)
    );

    a_excl0: assert property (@(posedge clock) disable iff (rst) !(!rn0 && !wn0))
        else $error("FAIL dut0 strobes low together");
    a_ale0: assert property (@(posedge clock) disable iff (rst) !(ale0 && (!rn0 || !wn0)))
        else $error("FAIL dut0 ale high during strobe");
    a_cs0: assert property (@(posedge clock) disable iff (rst) !(cs0 && (ale0 || !rn0 || !wn0)))
        else $error("FAIL dut0 activity outside cs_n");
    a_excl1: assert property (@(posedge clock) disable iff (rst) !(!rn1 && !wn1))
        else $error("FAIL dut1 strobes low together");
    a_ale1: assert property (@(posedge clock) disable iff (rst) !(ale1 && (!rn1 || !wn1)))
        else $error("FAIL dut1 ale high during strobe");
    a_cs1: assert property (@(posedge clock) disable iff (rst) !(cs1 && (ale1 || !rn1 || !wn1)))
        else $error("FAIL dut1 activity outside cs_n");

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Per-transaction bus recorder, cleared each time cs_n falls.
    logic       prev_cs = 1'b1;
    logic       prev_ale = 1'b0;
    int         hicnt = 0;
    int         gap = 0;
    int         idx, nrd, nwr, ndrv, extra;
    int         alec[2];
    logic [7:0] ab[2];

    task automatic rec_clear();
        idx = -1; nrd = 0; nwr = 0; ndrv = 0; extra = 0;
        alec[0] = 0; alec[1] = 0; ab[0] = 8'd0; ab[1] = 8'd0;
    endtask

    initial begin
        txn_t t;
        rec_clear();
        forever begin
            @(negedge clock);
            if (rst) begin
                rec_clear();
                prev_cs = 1'b1;
                prev_ale = 1'b0;
                hicnt = 0;
            end else begin
                check("no_dual_strobe", int'(!m_rn && !m_wn), 0);
                check("ale_vs_strobe", int'(m_ale && (!m_rn || !m_wn)), 0);
                check("cs_envelope", int'(m_cs && (m_ale || !m_rn || !m_wn)), 0);
                if (!m_cs && prev_cs) begin
                    gap = hicnt;
                    rec_clear();
                end
                hicnt = m_cs ? hicnt + 1 : 0;
                if (!m_cs) begin
                    if (m_ale && !prev_ale) begin
                        if (idx < 1) begin
                            idx++;
                            ab[idx] = m_abus;
                        end else extra++;
                    end
                    if (m_ale && idx >= 0) begin
                        alec[idx]++;
                        if (m_abus != ab[idx]) extra++;
                    end
                    if (!m_rn) nrd++;
                    if (!m_wn) nwr++;
                    if (m_rn && sbq.size() > 0 && m_dbus == sbq[0].wd) ndrv++;
                end
                prev_cs = m_cs;
                prev_ale = m_ale;
                if (m_rspv) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_rsp_valid", 1, 0);
                    end else begin
                        t = sbq.pop_front();
                        check("rsp_rdata", int'(m_rd), int'(t.rd));
                        check("latency", cyc - t.acc, 2 * (tale + tah) + tsu + tstb + thld);
                        check("addr_hi_byte", int'(ab[0]), int'(t.addr[15:8]));
                        check("addr_lo_byte", int'(ab[1]), int'(t.addr[7:0]));
                        check("ale_hi_cycles", alec[0], tale);
                        check("ale_lo_cycles", alec[1], tale);
                        check("r_n_low_cycles", nrd, t.w ? 0 : tstb);
                        check("w_n_low_cycles", nwr, t.w ? tstb : 0);
                        check("wdata_drive_cycles", ndrv, t.w ? tsu + tstb + thld : 0);
                        check("abus_unstable_or_extra_ale", extra, 0);
                    end
                end
            end
        end
    end

    task automatic set_mode(input logic s);
        sel = s;
        tale = s ? 1 : 2; tah = 1; tsu = 1; tstb = s ? 1 : 3; thld = 1;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, output logic rsp_at_accept);
        txn_t t;
        bit ok = 0;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 64; i++) begin
            if (m_ready) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        check("accept_timeout", int'(ok), 1);
        rsp_at_accept = m_rspv;
        @(posedge clock);
        #1;
        t.w = w; t.addr = a; t.wd = wd; t.rd = rd; t.acc = cyc;
        sbq.push_back(t);
    endtask

    task automatic drop();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (sbq.size() == 0) break;
        end
        check("completion_timeout", sbq.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        vec_t vt[6];
        logic r, r2;
        int seen;
        vt[0] = '{1'b1, 16'hA35C, 8'h7E, 8'h00, 8'h00};
        vt[1] = '{1'b0, 16'h0010, 8'h5A, 8'hC4, 8'hC4};
        vt[2] = '{1'b1, 16'hFFFF, 8'h01, 8'h00, 8'h00};
        vt[3] = '{1'b0, 16'h0000, 8'h3B, 8'h3C, 8'h3C};
        vt[4] = '{1'b1, 16'h0001, 8'h80, 8'h00, 8'h00};
        vt[5] = '{1'b0, 16'h8000, 8'h12, 8'hFF, 8'hFF};
        set_mode(1'b0);
        repeat (3) @(negedge clock);
        check("reset_cs_n", int'(cs0), 1);
        check("reset_ale", int'(ale0), 0);
        check("reset_r_n", int'(rn0), 1);
        check("reset_w_n", int'(wn0), 1);
        check("reset_abus", int'(abus0), 0);
        check("reset_req_ready", int'(ready0), 1);
        check("reset_rsp_valid", int'(rspv0), 0);
        check("reset_rsp_rdata", int'(rd0), 0);
        check("reset_cs_n_dut1", int'(cs1), 1);
        check("reset_req_ready_dut1", int'(ready1), 1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            periph_d = vt[i].pd;
            send(vt[i].w, vt[i].a, vt[i].wd, vt[i].exp_rd, r);
            drop();
            wait_idle();
        end

        periph_d = 8'h9D;
        send(1'b1, 16'h1234, 8'h11, 8'h00, r);
        send(1'b0, 16'h5678, 8'h22, 8'h9D, r2);
        check("b2b_accept_in_rsp_cycle", int'(r2), 1);
        drop();
        wait_idle();
        check("b2b_cs_n_gap", gap, 1);

        periph_d = 8'h6B;
        send(1'b0, 16'h2468, 8'h33, 8'h6B, r);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (m_rspv) begin
                req_valid = 1'b0;
                break;
            end
            check("busy_req_ready_low", int'(m_ready), 0);
            req_addr = 16'($urandom);
            req_write = 1'($urandom);
            req_wdata = 8'($urandom);
        end
        req_valid = 1'b0;
        wait_idle();

        send(1'b1, 16'hBEEF, 8'hA5, 8'h00, r);
        drop();
        for (int i = 0; i < 40; i++) begin
            if (!m_wn) break;
            @(negedge clock);
        end
        check("reached_write_strobe", int'(!m_wn), 1);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("abort_cs_n", int'(m_cs), 1);
        check("abort_w_n", int'(m_wn), 1);
        check("abort_ale", int'(m_ale), 0);
        check("abort_req_ready", int'(m_ready), 1);
        check("abort_rsp_valid", int'(m_rspv), 0);
        check("abort_dbus_released", int'(m_dbus == 8'hA5), 0);
        sbq.delete();
        @(negedge clock);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (m_rspv) seen++;
        end
        check("abort_no_rsp_valid", seen, 0);
        periph_d = 8'hE7;
        send(1'b0, 16'h0F0F, 8'h44, 8'hE7, r);
        drop();
        wait_idle();

        set_mode(1'b1);
        periph_d = 8'h96;
        send(1'b1, 16'hC3A5, 8'h5C, 8'h00, r);
        drop();
        wait_idle();
        send(1'b0, 16'h7001, 8'h44, 8'h96, r);
        drop();
        wait_idle();
        periph_d = 8'h2E;
        send(1'b1, 16'h00FF, 8'hD1, 8'h00, r);
        send(1'b0, 16'hFF00, 8'h4D, 8'h2E, r2);
        check("ones_b2b_accept_in_rsp_cycle", int'(r2), 1);
        drop();
        wait_idle();
        check("ones_b2b_cs_n_gap", gap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/th99_bus_master.md
Name: th99_bus_master

Overview:
- CPU-side initiator for the TH99 peripheral bus (cs_n, abus, ale, r_n, w_n, dbus).
- Takes single-beat read/write requests from a local valid/ready port.
- Sends the 16-bit address as two ALE-latched bytes, high then low, then runs one 8-bit read or write strobe and returns a one-cycle response.
- Sits between the system sequencer and the bus-attached display/peripheral block.

Parameters:
- T_ALE, 2: cycles ale is high per address byte (1..255).
- T_AH, 1: cycles abus is held after ale falls (1..255).
- T_SU, 1: cycles cs_n/data are set up before the strobe falls (1..255).
- T_STB, 3: cycles r_n or w_n is low (1..255).
- T_HLD, 1: cycles cs_n/data are held after the strobe rises (1..255).

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  16  target address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid on reads, 0 on writes.
- cs_n  out  1  chip select, active low.
- abus  out  8  address byte.
- ale  out  1  address latch enable; peripheral latches on its falling edge.
- r_n  out  1  read strobe; peripheral data is sampled while it is low, before it rises.
- w_n  out  1  write strobe; peripheral latches on its rising edge.
- dbus  inout  8  data bus; driven only during a write's SETUP/STROBE/HOLD, else Z.

Behaviour:
- All bus and response outputs are registered.
- Reset values: cs_n=1, ale=0, r_n=1, w_n=1, abus=0, dbus=Z, req_ready=1, rsp_valid=0, rsp_rdata=0, state=IDLE, counter=0.
- IDLE:
  - req_ready=1.
  - On valid&&ready, latch write/addr/wdata, go to AHI_ALE and load counter with T_ALE-1.
- AHI_ALE: cs_n=0, abus=addr[15:8], ale=1, for T_ALE cycles -> AHI_HOLD.
- AHI_HOLD: ale=0, abus held, for T_AH cycles -> ALO_ALE.
- ALO_ALE: abus=addr[7:0], ale=1, for T_ALE cycles -> ALO_HOLD.
- ALO_HOLD: ale=0, for T_AH cycles -> SETUP.
- SETUP: for T_SU cycles; on writes dbus=wdata from here on -> STROBE.
- STROBE:
  - r_n=0 (read) or w_n=0 (write), for T_STB cycles.
  - On a read, rdata is captured from dbus at the clock edge ending the last STROBE cycle, i.e. the same edge on which r_n returns high.
  - -> HOLD.
- HOLD: strobes high; cs_n and write data held for T_HLD cycles -> IDLE.
- Completion:
  - On the HOLD->IDLE edge: cs_n=1, dbus=Z, rsp_valid=1 for exactly one cycle, rsp_rdata=captured byte (read) or 0 (write).
  - req_ready is high in that same cycle, so a new request may be accepted then.
  - Minimum cs_n-high gap between transactions is 1 cycle.
- Transaction length from acceptance edge to rsp_valid: 2*(T_ALE+T_AH)+T_SU+T_STB+T_HLD cycles; 11 with defaults.
- req_ready=0 in every non-IDLE state; req_* changes while busy are ignored, because the request is latched at accept.
- Strobe rules:
  - r_n and w_n are never low simultaneously.
  - ale is never high while a strobe is low.
  - cs_n is low for the whole transaction.
- dbus is never driven during a read (no contention); it returns to Z on the same edge cs_n rises.
- Reset mid-operation: on the next edge all outputs take reset values and no rsp_valid is issued for the aborted transaction.
- Phase counter is 8 bits and counts down to 0. Parameters of 0 are illegal and are caught by an elaboration-time assertion.

Decomposition:
- Package th99_bus_pkg:
  - state enum (IDLE, AHI_ALE, AHI_HOLD, ALO_ALE, ALO_HOLD, SETUP, STROBE, HOLD).
  - default timing constants.
  - TH99_AW=16, TH99_DW=8.
- Sub-module th99_phase_timer:
  - loadable 8-bit down-counter; inputs load value and load strobe, output `done` at 0.
  - One instance, shared by all phases.

Test Plan:
- Write addr=16'hA35C, data=8'h7E, defaults:
  - abus shows A3 while ale is high for 2 cycles, then 5C while ale is high for 2 cycles.
  - w_n is low for 3 cycles with dbus=7E from SETUP through HOLD.
  - rsp_valid lands 11 cycles after accept, rsp_rdata=0.
- Read addr=16'h0010, bus model drives 8'hC4 while r_n is low:
  - rsp_rdata=C4 with rsp_valid; dbus is never driven by the DUT.
- Back-to-back: req_valid held high with two requests:
  - second accepted in the rsp_valid cycle.
  - cs_n high for exactly 1 cycle between transactions.
- Hold req_valid with changing req_addr during a busy read:
  - bus shows only the originally accepted address; req_ready=0 throughout.
- Assert rst during STROBE of a write:
  - next cycle cs_n=1, w_n=1, dbus=Z, req_ready=1, no rsp_valid.
  - a following read completes normally.
- All parameters=1:
  - transaction length 7 cycles.
  - strobe/ale exclusivity and the cs_n envelope are checked by assertions on every cycle.
